// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Purpose  : Shared FSM encodings and constants for the I2S stream controller.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int I2S_MARKER_BIT = 31;
  localparam int REQ_SIZE_WIDTH = 24;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_FETCH   = 2'd1,
    RD_PRESENT = 2'd2,
    RD_HOLD    = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_t;

  // A single-channel stream still needs a one-bit channel port.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : i2s_stream_fifo
// Purpose  : Circular FIFO with registered read port and fill/free levels.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic [ADDR_WIDTH:0]   o_free,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  w_rd;
  logic                  w_wr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  // A pop in the same cycle frees the slot, so a write into a full FIFO is kept.
  assign w_rd    = i_rd_en && !o_empty;
  assign w_wr    = i_wr_en && (!o_full || w_rd);
  assign o_fill  = r_wr_ptr - r_rd_ptr;
  assign o_free  = (ADDR_WIDTH+1)'(DEPTH) - o_fill;
  assign o_rd_data = r_rd_data;

  always_ff @(posedge clk) begin
    if (w_wr && !i_flush) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_rd) begin
        r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_stream_controller.sv
`default_nettype none
// ============================================================================
// Module   : i2s_stream_controller
// Purpose  : Streams memory bursts through a FIFO to an I2S writer with TDM
//            channel tracking; I2S_STREAM_UNDERRUN_CNT_EN adds underrun_count.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_stream_controller
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 10,
  parameter int LOW_WATER    = 256,
  parameter int MAX_BURST    = 512
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  output logic                                request_data,
  output logic [REQ_SIZE_WIDTH-1:0]           request_size,
  input  logic                                request_finished,
  input  logic                                memory_data_strobe,
  input  logic [31:0]                         memory_data,
  input  logic                                audio_data_request,
  output logic                                audio_data_ack,
  output logic [SAMPLE_WIDTH-1:0]             audio_data,
  output logic [chan_width(NUM_CHANNELS)-1:0] audio_channel,
  output logic                                underrun,
  output logic                                overflow
`ifdef I2S_STREAM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                         underrun_count
`endif
);

  localparam int CH_W = chan_width(NUM_CHANNELS);

  mem_state_t                r_mem_state, w_mem_next;
  rd_state_t                 r_rd_state, w_rd_next;
  logic [ADDR_WIDTH:0]       w_fill, w_free;
  logic                      w_empty, w_full, w_flush, w_wr_req, w_pop, w_marker;
  logic [31:0]               w_rd_data;
  logic                      w_unused_bits;
  logic [REQ_SIZE_WIDTH-1:0] w_burst, r_request_size;
  logic                      r_request_data, r_ack, r_underrun, r_overflow, r_fetch_empty;
  logic [SAMPLE_WIDTH-1:0]   r_audio_data;
  logic [CH_W-1:0]           r_audio_channel, r_chan, w_chan_inc;

  // The FIFO is only cleared once any outstanding burst has been closed.
  assign w_flush  = !enable && (r_mem_state == MEM_IDLE);
  assign w_wr_req = memory_data_strobe && enable;
  assign w_pop    = (r_rd_state == RD_FETCH) && !w_empty;
  assign w_marker = !r_fetch_empty && w_rd_data[I2S_MARKER_BIT];
  assign w_chan_inc = (r_chan == CH_W'(NUM_CHANNELS - 1)) ? '0 : r_chan + CH_W'(1);
  assign w_burst  = (REQ_SIZE_WIDTH'(w_free) > REQ_SIZE_WIDTH'(MAX_BURST)) ?
                    REQ_SIZE_WIDTH'(MAX_BURST) : REQ_SIZE_WIDTH'(w_free);
  assign w_unused_bits = ^w_rd_data;

  i2s_stream_fifo #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (w_flush),
    .i_wr_en   (w_wr_req),
    .i_wr_data (memory_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_fill    (w_fill),
    .o_free    (w_free),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  always_comb begin
    w_mem_next = r_mem_state;
    case (r_mem_state)
      MEM_IDLE: if (enable && (32'(w_fill) <= 32'(LOW_WATER))) w_mem_next = MEM_REQ;
      MEM_REQ:  w_mem_next = MEM_WAIT;
      MEM_WAIT: if (request_finished) w_mem_next = MEM_IDLE;
      default:  w_mem_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_state    <= MEM_IDLE;
      r_request_data <= 1'b0;
      r_request_size <= '0;
    end else begin
      r_mem_state    <= w_mem_next;
      r_request_data <= (r_mem_state == MEM_REQ);
      if (r_mem_state == MEM_REQ) r_request_size <= w_burst;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE:    if (enable && audio_data_request && !r_ack) w_rd_next = RD_FETCH;
      RD_FETCH:   w_rd_next = RD_PRESENT;
      RD_PRESENT: w_rd_next = RD_HOLD;
      RD_HOLD:    if (!audio_data_request) w_rd_next = RD_IDLE;
      default:    w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state      <= RD_IDLE;
      r_ack           <= 1'b0;
      r_underrun      <= 1'b0;
      r_fetch_empty   <= 1'b0;
      r_audio_data    <= '0;
      r_audio_channel <= '0;
      r_chan          <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      r_underrun <= 1'b0;
      if (r_rd_state == RD_FETCH) r_fetch_empty <= w_empty;
      if (r_rd_state == RD_PRESENT) begin
        r_ack        <= 1'b1;
        r_underrun   <= r_fetch_empty;
        r_audio_data <= r_fetch_empty ? '0 : w_rd_data[SAMPLE_WIDTH-1:0];
        // A frame-start marker on a non-zero slot resynchronises the slot counter.
        if (w_marker && (r_chan != '0)) begin
          r_audio_channel <= '0;
          r_chan          <= CH_W'(1);
        end else begin
          r_audio_channel <= r_chan;
          r_chan          <= w_chan_inc;
        end
      end else if ((r_rd_state == RD_HOLD) && !audio_data_request) begin
        r_ack <= 1'b0;
      end
      if (!enable) r_chan <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (!enable) begin
      r_overflow <= 1'b0;
    end else if (w_wr_req && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef I2S_STREAM_UNDERRUN_CNT_EN
  logic        r_enable_q;
  logic [15:0] r_underrun_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable_q       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      r_enable_q <= enable;
      if (enable && !r_enable_q) begin
        r_underrun_count <= '0;
      end else if ((r_rd_state == RD_PRESENT) && r_fetch_empty && (r_underrun_count != 16'hFFFF)) begin
        r_underrun_count <= r_underrun_count + 16'd1;
      end
    end
  end

  assign underrun_count = r_underrun_count;
`endif

  assign request_data   = r_request_data;
  assign request_size   = r_request_size;
  assign audio_data_ack = r_ack;
  assign audio_data     = r_audio_data;
  assign audio_channel  = r_audio_channel;
  assign underrun       = r_underrun;
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stream_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_stream_controller
// Purpose  : Scoreboard bench for i2s_stream_controller (2- and 4-channel DUTs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_stream_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        en_a = 0, fin_a = 0, stb_a = 0, req_a = 0;
  logic [31:0] md_a = 0;
  logic        rq_a, ack_a, unr_a, ovf_a;
  logic [23:0] rsz_a, ad_a;
  logic [0:0]  ch_a;

  logic        en_b = 0, fin_b = 0, stb_b = 0, req_b = 0;
  logic [31:0] md_b = 0;
  logic        rq_b, ack_b, unr_b, ovf_b;
  logic [23:0] rsz_b, ad_b;
  logic [1:0]  ch_b;
`ifdef I2S_STREAM_UNDERRUN_CNT_EN
  logic [15:0] ucnt_a, ucnt_b;
`endif

  i2s_stream_controller #(.NUM_CHANNELS(2)) u_dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .request_data(rq_a), .request_size(rsz_a),
    .request_finished(fin_a), .memory_data_strobe(stb_a), .memory_data(md_a),
    .audio_data_request(req_a), .audio_data_ack(ack_a), .audio_data(ad_a),
    .audio_channel(ch_a), .underrun(unr_a), .overflow(ovf_a)
`ifdef I2S_STREAM_UNDERRUN_CNT_EN
    , .underrun_count(ucnt_a)
`endif
  );

  i2s_stream_controller #(.NUM_CHANNELS(4)) u_dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .request_data(rq_b), .request_size(rsz_b),
    .request_finished(fin_b), .memory_data_strobe(stb_b), .memory_data(md_b),
    .audio_data_request(req_b), .audio_data_ack(ack_b), .audio_data(ad_b),
    .audio_channel(ch_b), .underrun(unr_b), .overflow(ovf_b)
`ifdef I2S_STREAM_UNDERRUN_CNT_EN
    , .underrun_count(ucnt_b)
`endif
  );

  typedef struct {
    logic [23:0] data;
    logic [1:0]  ch;
    logic        unr;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic ack_a_q = 1'b0;
  logic ack_b_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: score each rising ack against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack_a && !ack_a_q) begin
      if (q_a.size() == 0) chk("a_unexpected_ack", 1, 0);
      else begin
        e_a = q_a.pop_front();
        chk("a_data", ad_a, e_a.data);
        chk("a_channel", ch_a, e_a.ch);
        chk("a_underrun", unr_a, e_a.unr);
        chk("a_ack_latency", cyc - e_a.cyc, 2);
      end
    end
    ack_a_q = ack_a;
  end

  always @(negedge clk) begin
    if (ack_b && !ack_b_q) begin
      if (q_b.size() == 0) chk("b_unexpected_ack", 1, 0);
      else begin
        e_b = q_b.pop_front();
        chk("b_data", ad_b, e_b.data);
        chk("b_channel", ch_b, e_b.ch);
        chk("b_underrun", unr_b, e_b.unr);
        chk("b_ack_latency", cyc - e_b.cyc, 2);
      end
    end
    ack_b_q = ack_b;
  end

  task automatic start_read(input int sel, input logic [23:0] d, input logic [1:0] ch, input logic unr);
    exp_t e;
    e.data = d; e.ch = ch; e.unr = unr; e.cyc = cyc + 1;
    if (sel == 0) begin q_a.push_back(e); req_a = 1'b1; end
    else          begin q_b.push_back(e); req_b = 1'b1; end
  endtask

  task automatic finish_read(input int sel);
    int n = 0;
    while (!(sel == 0 ? ack_a : ack_b) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(sel == 0 ? ack_a : ack_b)) chk("ack_timeout", 0, 1);
    if (sel == 0) req_a = 1'b0; else req_b = 1'b0;
    @(negedge clk);
    chk("ack_release", sel == 0 ? ack_a : ack_b, 0);
    chk("underrun_single_pulse", sel == 0 ? unr_a : unr_b, 0);
  endtask

  task automatic rd(input int sel, input logic [23:0] d, input logic [1:0] ch, input logic unr);
    start_read(sel, d, ch, unr);
    finish_read(sel);
  endtask

  task automatic strobe(input int sel, input logic [31:0] d);
    if (sel == 0) begin stb_a = 1'b1; md_a = d; end
    else          begin stb_b = 1'b1; md_b = d; end
    @(negedge clk);
    if (sel == 0) stb_a = 1'b0; else stb_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int  n;
  int  pulses;
  logic [1:0] exp_ch;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_request_data", rq_a, 0);
    chk("rst_request_size", rsz_a, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_audio_data", ad_a, 0);
    chk("rst_channel", ch_a, 0);
    chk("rst_underrun", unr_a, 0);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_b_request_data", rq_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Empty FIFO: one burst request of MAX_BURST, then wait for completion.
    en_a = 1'b1;
    n = 0;
    while (!rq_a && n < 10) begin @(negedge clk); n++; end
    chk("t1_request_pulse", rq_a, 1);
    chk("t1_request_size", rsz_a, 512);
    pulses = 0;
    repeat (10) begin @(negedge clk); if (rq_a) pulses++; end
    chk("t1_single_pulse", pulses, 0);
    chk("t1_size_held", rsz_a, 512);

    // Four marked words on a 2-channel stream.
    strobe(0, 32'h80000111);
    strobe(0, 32'h00000222);
    strobe(0, 32'h80000333);
    strobe(0, 32'h00000444);
    rd(0, 24'h000111, 2'd0, 1'b0);
    rd(0, 24'h000222, 2'd1, 1'b0);
    rd(0, 24'h000333, 2'd0, 1'b0);
    rd(0, 24'h000444, 2'd1, 1'b0);

    // Underrun on an empty FIFO.
    rd(0, 24'h0, 2'd0, 1'b1);
`ifdef I2S_STREAM_UNDERRUN_CNT_EN
    chk("t3_underrun_count", ucnt_a, 1);
`endif

    // Early frame start on a 4-channel stream.
    en_b = 1'b1;
    strobe(1, 32'h80000001);
    strobe(1, 32'h00000002);
    strobe(1, 32'h80000003);
    strobe(1, 32'h00000004);
    rd(1, 24'h000001, 2'd0, 1'b0);
    rd(1, 24'h000002, 2'd1, 1'b0);
    rd(1, 24'h000003, 2'd0, 1'b0);
    rd(1, 24'h000004, 2'd1, 1'b0);

    // Fill to full, then three strobes around one pop: the middle one lands.
    exp_ch = 2'd1;
    for (int i = 0; i < 1024; i++) strobe(0, 32'(i));
    chk("t5_no_overflow_at_full", ovf_a, 0);
    start_read(0, 24'h0, exp_ch, 1'b0);
    exp_ch = exp_ch ^ 2'd1;
    stb_a = 1'b1; md_a = 32'h000005A5;
    @(negedge clk); md_a = 32'h00000B0B;
    @(negedge clk); md_a = 32'h00000C0C;
    @(negedge clk); stb_a = 1'b0;
    finish_read(0);
    chk("t5_overflow_set", ovf_a, 1);
    for (int i = 1; i < 1024; i++) begin
      rd(0, 24'(i), exp_ch, 1'b0);
      exp_ch = exp_ch ^ 2'd1;
    end
    rd(0, 24'h000B0B, exp_ch, 1'b0);
    exp_ch = exp_ch ^ 2'd1;
    rd(0, 24'h0, exp_ch, 1'b1);
    chk("t5_overflow_sticky", ovf_a, 1);
    en_a = 1'b0;
    @(negedge clk);
    chk("t5_overflow_cleared", ovf_a, 0);
    fin_a = 1'b1; @(negedge clk); fin_a = 1'b0;
    repeat (3) @(negedge clk);

    // Enable drops mid-burst with a handshake in flight.
    en_a = 1'b1;
    n = 0;
    while (!rq_a && n < 10) begin @(negedge clk); n++; end
    chk("t6_request_pulse", rq_a, 1);
    strobe(0, 32'h80000AAA);
    strobe(0, 32'h00000BBB);
    start_read(0, 24'h000AAA, 2'd0, 1'b0);
    @(negedge clk);
    en_a = 1'b0;
    stb_a = 1'b1; md_a = 32'h80000F0F;
    repeat (5) @(negedge clk);
    stb_a = 1'b0;
    fin_a = 1'b1; @(negedge clk); fin_a = 1'b0;
    finish_read(0);
    repeat (2) @(negedge clk);
    en_a = 1'b1;
    rd(0, 24'h0, 2'd0, 1'b1);
`ifdef I2S_STREAM_UNDERRUN_CNT_EN
    chk("t6_underrun_count_restart", ucnt_a, 1);
`endif

    repeat (3) @(negedge clk);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
